// File: rtl/pic_pkg.sv
// Shared types and index helpers for the interrupt controller core.
// Latency: none (declarations only).
// Backpressure: not applicable.
package pic_pkg;

    // Largest channel count the index arithmetic is sized for.
    localparam int PIC_MAX_IRQ = 32;

    // Request/acknowledge handshake states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        ACK  = 2'd2
    } pic_state_t;

    // Channel reached by stepping 'off' places from 'base' around an n-entry ring.
    function automatic int rot_idx(input int base, input int off, input int n);
        return (base + off) % n;
    endfunction

endpackage

// File: rtl/pic_prio_resolver.sv
// Rotating priority encoder: finds the highest-priority set bit, starting at prio_base.
// Latency: purely combinational.
// Backpressure: none; output follows inputs in the same cycle.
module pic_prio_resolver
    import pic_pkg::*;
#(
    parameter int NUM_IRQ = 8,
    parameter int IDX_W   = $clog2(NUM_IRQ)
) (
    input  logic [NUM_IRQ-1:0] req,
    input  logic [IDX_W-1:0]   prio_base,
    output logic               found,
    output logic [IDX_W-1:0]   idx
);

    // Walk the ring from lowest to highest priority so the highest-priority hit is written last.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int off = NUM_IRQ - 1; off >= 0; off--) begin
            if (req[rot_idx(int'(prio_base), off, NUM_IRQ)]) begin
                found = 1'b1;
                idx   = IDX_W'(rot_idx(int'(prio_base), off, NUM_IRQ));
            end
        end
    end

endmodule

// File: rtl/pic_irq_core.sv
// Request latch, fully-nested priority resolver and INTA/EOI handshake (PIC_AEOI_EN: automatic EOI).
// Latency: irq_in edge to int_req 2 cycles; inta to vec_valid 1 cycle.
// Backpressure: int_req holds until inta; requests stay latched in irr while masked or blocked by isr.
module pic_irq_core
    import pic_pkg::*;
#(
    parameter int NUM_IRQ = 8,
    parameter int IDX_W   = $clog2(NUM_IRQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic               level_mode,
    input  logic [NUM_IRQ-1:0] imr,
    input  logic               auto_rotate,
    input  logic               inta,
    input  logic               eoi,
    output logic               int_req,
    output logic               vec_valid,
    output logic [IDX_W-1:0]   vec_idx,
    output logic               spurious,
    output logic [NUM_IRQ-1:0] irr,
    output logic [NUM_IRQ-1:0] isr
);

    pic_state_t         state;
    pic_state_t         state_nxt;

    logic [NUM_IRQ-1:0] prev_irq;
    logic [NUM_IRQ-1:0] irr_q;
    logic [NUM_IRQ-1:0] isr_q;
    logic [IDX_W-1:0]   prio_base;

    logic [NUM_IRQ-1:0] cand_req;
    logic               cand_found;
    logic [IDX_W-1:0]   cand_idx;
    logic               top_found;
    logic [IDX_W-1:0]   top_idx;
    logic [IDX_W-1:0]   cand_rank;
    logic [IDX_W-1:0]   top_rank;
    logic               eligible;

    logic               ack_take;
    logic               ack_spur;
    logic [NUM_IRQ-1:0] ack_set;
    logic [NUM_IRQ-1:0] edge_set;
    logic [NUM_IRQ-1:0] irr_nxt;

    logic               retire;
    logic [IDX_W-1:0]   retire_idx;
    logic [NUM_IRQ-1:0] retire_clr;
    logic [NUM_IRQ-1:0] isr_nxt;
    logic [IDX_W-1:0]   base_nxt;

    // Masked bits stay latched in irr; they are only hidden from the resolver.
    assign cand_req = irr_q & ~imr;

    pic_prio_resolver #(
        .NUM_IRQ   (NUM_IRQ),
        .IDX_W     (IDX_W)
    ) u_cand_resolver (
        .req       (cand_req),
        .prio_base (prio_base),
        .found     (cand_found),
        .idx       (cand_idx)
    );

    pic_prio_resolver #(
        .NUM_IRQ   (NUM_IRQ),
        .IDX_W     (IDX_W)
    ) u_isr_resolver (
        .req       (isr_q),
        .prio_base (prio_base),
        .found     (top_found),
        .idx       (top_idx)
    );

    // Rank 0 is the highest priority; ranks are distances from prio_base around the ring.
    assign cand_rank = IDX_W'(rot_idx(int'(cand_idx), NUM_IRQ - int'(prio_base), NUM_IRQ));
    assign top_rank  = IDX_W'(rot_idx(int'(top_idx),  NUM_IRQ - int'(prio_base), NUM_IRQ));

    // Fully nested: a request only interrupts a strictly lower-priority service.
    assign eligible = cand_found && (!top_found || (cand_rank < top_rank));

    // The candidate is re-resolved in the inta cycle; a vanished request becomes a spurious ack.
    assign ack_take = (state == PEND) && inta && eligible;
    assign ack_spur = (state == PEND) && inta && !eligible;
    assign ack_set  = ack_take ? (NUM_IRQ'(1) << cand_idx) : '0;

    // Edge set is OR-ed after the ack clear so a same-cycle new edge stays latched.
    assign edge_set = irq_in & ~prev_irq;
    assign irr_nxt  = level_mode ? irq_in : ((irr_q & ~ack_set) | edge_set);

`ifdef PIC_AEOI_EN
    // Automatic EOI retires the channel acknowledged in the previous cycle; eoi is unused.
    assign retire     = (state == ACK) && !spurious;
    assign retire_idx = vec_idx;
`else
    // Non-specific EOI retires the highest-priority in-service channel.
    assign retire     = eoi && top_found;
    assign retire_idx = top_idx;
`endif

    // Retire acts on the pre-ack isr, so a bit set on this edge is never the one cleared.
    assign retire_clr = retire ? (NUM_IRQ'(1) << retire_idx) : '0;
    assign isr_nxt    = (isr_q & ~retire_clr) | ack_set;
    assign base_nxt   = (retire && auto_rotate) ?
                        IDX_W'(rot_idx(int'(retire_idx), 1, NUM_IRQ)) : prio_base;

    // Handshake state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs; inta outside PEND is ignored.
    always_comb begin
        state_nxt = state;
        int_req   = 1'b0;
        vec_valid = 1'b0;
        case (state)
            IDLE: begin
                if (eligible) begin
                    state_nxt = PEND;
                end
            end
            PEND: begin
                int_req = 1'b1;
                if (inta) begin
                    state_nxt = ACK;
                end else if (!eligible) begin
                    state_nxt = IDLE;
                end
            end
            ACK: begin
                vec_valid = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Request, in-service, rotation and vector registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_irq  <= '0;
            irr_q     <= '0;
            isr_q     <= '0;
            prio_base <= '0;
            vec_idx   <= '0;
            spurious  <= 1'b0;
        end else begin
            prev_irq  <= irq_in;
            irr_q     <= irr_nxt;
            isr_q     <= isr_nxt;
            prio_base <= base_nxt;
            if (ack_take) begin
                vec_idx  <= cand_idx;
                spurious <= 1'b0;
            end else if (ack_spur) begin
                vec_idx  <= IDX_W'(NUM_IRQ - 1);
                spurious <= 1'b1;
            end
        end
    end

    assign irr = irr_q;
    assign isr = isr_q;

endmodule

// File: doc/pic_irq_core.md
Name: pic_irq_core

Overview:
- Parametrised, clocked successor to the 8259-style IRR and priority-resolver pair.
- Latches edge- or level-sensitive requests and applies the interrupt mask.
- Resolves priority with fully-nested masking against the In-Service Register (ISR), with optional automatic rotation.
- Runs the acknowledge/EOI handshake with the control logic; sits between the raw IR pins and the control/data-bus logic.

Parameters:
- NUM_IRQ, 8, number of interrupt request channels (2..32).
- IDX_W, $clog2(NUM_IRQ), width of channel index fields (derived; not overridden).

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- irq_in  in  NUM_IRQ  raw request lines, bit i = IR i; synchronous to clk.
- level_mode  in  1  1 = level-sensitive, 0 = rising-edge-sensitive.
- imr  in  NUM_IRQ  interrupt mask; 1 = channel masked.
- auto_rotate  in  1  1 = serviced channel becomes lowest priority on EOI.
- inta  in  1  acknowledge pulse from control logic, one cycle.
- eoi  in  1  non-specific EOI pulse, one cycle.
- int_req  out  1  interrupt request to CPU side.
- vec_valid  out  1  one-cycle strobe; vec_idx is valid.
- vec_idx  out  IDX_W  acknowledged channel index.
- spurious  out  1  qualifies vec_valid: the request vanished before the ack.
- irr  out  NUM_IRQ  Interrupt Request Register, for readback.
- isr  out  NUM_IRQ  In-Service Register, for readback.

Behaviour:
- Reset values: irr=0, isr=0, prev_irq=0, prio_base=0, state=IDLE, int_req=0, vec_valid=0, vec_idx=0, spurious=0.
- IRR update is registered, once per clk.
  - Edge mode: bit i sets when irq_in[i]=1 and prev_irq[i]=0. It stays set until acknowledged.
  - Level mode: irr[i] = irq_in[i] each cycle. The ack clear has no lasting effect while the line stays high.
  - prev_irq <= irq_in every cycle, in both modes.
- Masking: imr does not clear IRR. Masked bits are excluded from resolution only. Unmasking a latched bit makes it eligible the next cycle.
- Priority order: channel prio_base is highest, then prio_base+1, and so on, wrapping modulo NUM_IRQ.
- Candidate: the highest-priority bit of irr & ~imr.
  - It is eligible only if strictly higher priority than the highest-priority set isr bit, or isr==0 (fully nested).
- FSM states: IDLE, PEND, ACK.
  - IDLE -> PEND when an eligible candidate exists. int_req=1 from the cycle after the request is seen in irr.
  - PEND -> IDLE if the candidate disappears without inta. int_req drops.
  - PEND + inta -> ACK. The candidate is re-resolved in the inta cycle.
    - If it is still present: isr[c] sets, irr[c] clears (edge mode), vec_idx=c.
    - If none is present: vec_idx=NUM_IRQ-1, spurious=1, isr unchanged.
  - ACK: vec_valid=1 for exactly one cycle and int_req=0. Next state is IDLE.
  - inta in IDLE or ACK is ignored.
- EOI (non-specific): clears the highest-priority set isr bit h.
  - If auto_rotate=1: prio_base <= (h+1) mod NUM_IRQ.
  - EOI with isr==0: no effect, no rotation.
- Simultaneous eoi and inta in the same cycle:
  - EOI is applied to the pre-ack isr.
  - The new isr bit is set in the same edge; the new bit is never the one cleared.
- irq edge coinciding with ack of the same channel: set wins. The bit stays latched for re-service.
- rst_n assertion mid-operation: immediate clear of all state, including mid-ACK; no vec_valid is issued.
- Latency: irq_in edge to int_req = 2 cycles. inta to vec_valid = 1 cycle.

Optional Feature:
- Macro PIC_AEOI_EN.
- Defined: automatic EOI.
  - In ACK, the isr bit just set is cleared on the following edge.
  - Rotation is applied there as for EOI if auto_rotate=1.
  - The eoi input is ignored.
- Undefined: isr bits persist until an explicit eoi.

Decomposition:
- Package pic_pkg holds:
  - the state enum (IDLE/PEND/ACK);
  - constant PIC_MAX_IRQ=32;
  - function rot_idx(base, off, n) for modulo index math.
- Sub-module pic_prio_resolver: combinational rotating priority encoder.
  - Inputs: req vector, prio_base.
  - Outputs: found and idx.
  - Instantiated twice: once for the irr&~imr candidate, once for the isr highest bit.

Test Plan:
- Edge mode, imr=0, pulse irq_in[3] -> int_req=1 two cycles later; inta -> vec_valid with vec_idx=3, isr=8'h08, irr=0.
- Nesting: isr[2] in service, raise IR5 -> int_req stays 0. Raise IR1 -> int_req=1, ack gives vec_idx=1, isr=8'h06.
- Rotation: auto_rotate=1, service IR4 then eoi -> prio_base=5. Then simultaneous IR0 and IR6 -> vec_idx=6.
- Masking: imr[2]=1, edge on IR2 -> irr[2]=1, int_req=0. Clear imr[2] -> int_req=1 next cycle.
- Spurious: level mode, IR7 high -> int_req; drop IR7 one cycle before inta -> vec_idx=7, spurious=1, isr=0.
- Reset mid-ACK and AEOI: assert rst_n=0 during ACK -> all outputs 0. With PIC_AEOI_EN, ack IR3 -> isr back to 0 two cycles after inta.
